// File: rtl/bus_fabric.sv
// bus_fabric: registered memory-map interconnect, one CPU master to NUM_SLAVES
// slaves. Decodes the master address against per-slave base/size windows,
// forwards a rebased request to the selected slave, and returns registered
// read data with a ready/error completion.
//
// Optional feature macro: BUS_FABRIC_TIMEOUT_EN
//   defined   - ACCESS aborts with an error after TIMEOUT_CYCLES without ready
//   undefined - no timeout counter, ACCESS waits indefinitely for ready
//
// FSM states:
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | waiting for i_request; decodes and latches the request
//   ST_ACCESS | slave enable held; waiting for the selected slave's ready
//   ST_DONE   | o_ready (and o_error) held until the master drops i_request

module bus_fabric #(
  parameter int unsigned                NUM_SLAVES     = 4,
  parameter logic [NUM_SLAVES*32-1:0]   SLAVE_BASE     = {32'h50000000, 32'h10000000,
                                                          32'h00010000, 32'h00000000},
  parameter logic [NUM_SLAVES*32-1:0]   SLAVE_SIZE     = {32'h00000010, 32'h10000000,
                                                          32'h00010000, 32'h00010000},
  parameter int unsigned                TIMEOUT_CYCLES = 255
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic                     i_request,
  input  logic                     i_rw,
  input  logic [31:0]              i_address,
  input  logic [31:0]              i_wdata,
  output logic [31:0]              o_rdata,
  output logic                     o_ready,
  output logic                     o_error,
  output logic [NUM_SLAVES-1:0]    o_slave_enable,
  output logic                     o_slave_rw,
  output logic [31:0]              o_slave_address,
  output logic [31:0]              o_slave_wdata,
  input  logic [NUM_SLAVES*32-1:0] i_slave_rdata,
  input  logic [NUM_SLAVES-1:0]    i_slave_ready
);

  localparam int unsigned IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [NUM_SLAVES-1:0] enable_q, enable_d;
  logic                  rw_q, rw_d;
  logic [31:0]           addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  ready_q, ready_d;
  logic                  error_q, error_d;

`ifdef BUS_FABRIC_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  // Address decode and selected-slave response mux
  logic             hit;
  logic [IDX_W-1:0] hit_idx;
  logic [31:0]      hit_base;
  logic             sel_ready;
  logic [31:0]      sel_rdata;

  // Window decode; scanning from the top index down lets the lowest index
  // win on overlap. 33-bit limits keep base+size = 2^32 from wrapping.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    hit_base = '0;
    for (int k = NUM_SLAVES - 1; k >= 0; k--) begin
      if (({1'b0, i_address} >= {1'b0, SLAVE_BASE[k*32 +: 32]}) &&
          ({1'b0, i_address} <  ({1'b0, SLAVE_BASE[k*32 +: 32]} +
                                 {1'b0, SLAVE_SIZE[k*32 +: 32]}))) begin
        hit      = 1'b1;
        hit_idx  = IDX_W'(k);
        hit_base = SLAVE_BASE[k*32 +: 32];
      end
    end
  end

  // Only the latched slave's ready and read data are ever looked at
  always_comb begin
    sel_ready = i_slave_ready[idx_q];
    sel_rdata = i_slave_rdata[int'(idx_q)*32 +: 32];
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    enable_d = enable_q;
    rw_d     = rw_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    ready_d  = ready_q;
    error_d  = error_q;
`ifdef BUS_FABRIC_TIMEOUT_EN
    cnt_d    = cnt_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (i_request) begin
          if (hit) begin
            idx_d    = hit_idx;
            enable_d = NUM_SLAVES'(1) << hit_idx;
            rw_d     = i_rw;
            addr_d   = i_address - hit_base;
            wdata_d  = i_wdata;
`ifdef BUS_FABRIC_TIMEOUT_EN
            cnt_d    = '0;
`endif
            state_d  = ST_ACCESS;
          end else begin
            rdata_d  = '0;
            ready_d  = 1'b1;
            error_d  = 1'b1;
            state_d  = ST_DONE;
          end
        end
      end

      ST_ACCESS: begin
        if (sel_ready) begin
          rdata_d  = rw_q ? 32'h0 : sel_rdata;
          enable_d = '0;
          ready_d  = 1'b1;
          error_d  = 1'b0;
          state_d  = ST_DONE;
        end
`ifdef BUS_FABRIC_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          rdata_d  = '0;
          enable_d = '0;
          ready_d  = 1'b1;
          error_d  = 1'b1;
          state_d  = ST_DONE;
        end else begin
          cnt_d    = cnt_q + 1'b1;
        end
`endif
      end

      ST_DONE: begin
        // Dropping the request is what returns us to IDLE, which forces
        // at least one low cycle between transactions.
        if (!i_request) begin
          ready_d = 1'b0;
          error_d = 1'b0;
          state_d = ST_IDLE;
        end
      end

      default: begin
        enable_d = '0;
        ready_d  = 1'b0;
        error_d  = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      enable_q <= '0;
      rw_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      ready_q  <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      enable_q <= enable_d;
      rw_q     <= rw_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      ready_q  <= ready_d;
      error_q  <= error_d;
    end
  end

`ifdef BUS_FABRIC_TIMEOUT_EN
  // ACCESS timeout counter
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  assign o_rdata         = rdata_q;
  assign o_ready         = ready_q;
  assign o_error         = error_q;
  assign o_slave_enable  = enable_q;
  assign o_slave_rw      = rw_q;
  assign o_slave_address = addr_q;
  assign o_slave_wdata   = wdata_q;

endmodule

// File: tb/tb_bus_fabric.sv
// Directed testbench for bus_fabric (default 4-slave memory map).
// Slave windows: s0 0x00000000+0x10000, s1 0x00010000+0x10000,
//                s2 0x10000000+0x10000000, s3 0x50000000+0x10.

module tb_bus_fabric;

  logic         clk = 1'b0;
  logic         rst;
  logic         req;
  logic         rw;
  logic [31:0]  addr;
  logic [31:0]  wdata;
  logic [31:0]  rdata;
  logic         ready;
  logic         error;
  logic [3:0]   s_en;
  logic         s_rw;
  logic [31:0]  s_addr;
  logic [31:0]  s_wdata;
  logic [127:0] s_rdata;
  logic [3:0]   s_ready;

  int checks = 0;
  int errors = 0;

  bus_fabric #(
    .NUM_SLAVES     (4),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .i_clock         (clk),
    .i_reset         (rst),
    .i_request       (req),
    .i_rw            (rw),
    .i_address       (addr),
    .i_wdata         (wdata),
    .o_rdata         (rdata),
    .o_ready         (ready),
    .o_error         (error),
    .o_slave_enable  (s_en),
    .o_slave_rw      (s_rw),
    .o_slave_address (s_addr),
    .o_slave_wdata   (s_wdata),
    .i_slave_rdata   (s_rdata),
    .i_slave_ready   (s_ready)
  );

  always #5 clk = ~clk;

  // advance one clock; outputs are sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 1'b1; rw = 1'b0; addr = 32'h0000_0010; wdata = '0;
    s_rdata = '0; s_ready = 4'b1111;
    tick(); tick();
    checks++;
    if (ready !== 1'b0 || error !== 1'b0 || rdata !== 32'h0) begin
      errors++; $display("FAIL reset_resp: ready=%b error=%b rdata=%h, required 0 0 0", ready, error, rdata);
    end
    checks++;
    if (s_en !== 4'b0 || s_rw !== 1'b0 || s_addr !== 32'h0 || s_wdata !== 32'h0) begin
      errors++; $display("FAIL reset_slave: en=%b rw=%b addr=%h wdata=%h, required all 0", s_en, s_rw, s_addr, s_wdata);
    end
    rst = 1'b0; req = 1'b0; s_ready = '0;
    tick();
  endtask

  task automatic test_read_basic();
    s_rdata[31:0] = 32'h1234_5678; s_ready = 4'b0001;
    req = 1'b1; rw = 1'b0; addr = 32'h0000_0010;
    tick();
    checks++;
    if (s_en !== 4'b0001 || s_addr !== 32'h10 || ready !== 1'b0) begin
      errors++; $display("FAIL read_select: en=%b addr=%h ready=%b, required 0001 00000010 0", s_en, s_addr, ready);
    end
    tick();
    checks++;
    if (ready !== 1'b1 || error !== 1'b0 || rdata !== 32'h1234_5678 || s_en !== 4'b0) begin
      errors++; $display("FAIL read_done: ready=%b error=%b rdata=%h en=%b, required 1 0 12345678 0000", ready, error, rdata, s_en);
    end
    req = 1'b0; s_ready = '0;
    tick();
    checks++;
    if (ready !== 1'b0 || rdata !== 32'h1234_5678) begin
      errors++; $display("FAIL read_release: ready=%b rdata=%h, required 0 12345678", ready, rdata);
    end
  endtask

  task automatic test_write_delayed();
    s_rdata[95:64] = 32'hDEAD_BEEF; s_ready = '0;
    req = 1'b1; rw = 1'b1; addr = 32'h1000_0104; wdata = 32'hCAFE_F00D;
    tick();
    // master side wanders and other slaves raise ready; both must be ignored
    addr = 32'h0000_0000; wdata = 32'h1111_1111; rw = 1'b0; s_ready = 4'b1011;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (s_en !== 4'b0100 || s_addr !== 32'h104 || s_rw !== 1'b1 ||
          s_wdata !== 32'hCAFE_F00D || ready !== 1'b0) begin
        errors++; $display("FAIL write_hold[%0d]: en=%b addr=%h rw=%b wdata=%h ready=%b, required 0100 00000104 1 cafef00d 0",
                           i, s_en, s_addr, s_rw, s_wdata, ready);
      end
      if (i < 4) tick();
    end
    s_ready = 4'b0100;
    tick();
    checks++;
    if (ready !== 1'b1 || error !== 1'b0 || rdata !== 32'h0 || s_en !== 4'b0) begin
      errors++; $display("FAIL write_done: ready=%b error=%b rdata=%h en=%b, required 1 0 00000000 0000", ready, error, rdata, s_en);
    end
    req = 1'b0; s_ready = '0;
    tick();
  endtask

  task automatic test_unmapped();
    logic [31:0] bad [3];
    bad[0] = 32'h4000_0000; bad[1] = 32'h5000_0010; bad[2] = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      s_ready = 4'b1111;
      req = 1'b1; rw = 1'b0; addr = bad[i];
      tick();
      checks++;
      if (ready !== 1'b1 || error !== 1'b1 || rdata !== 32'h0 || s_en !== 4'b0) begin
        errors++; $display("FAIL unmapped_%h: ready=%b error=%b rdata=%h en=%b, required 1 1 00000000 0000", bad[i], ready, error, rdata, s_en);
      end
      tick();
      checks++;
      if (ready !== 1'b1 || error !== 1'b1) begin
        errors++; $display("FAIL unmapped_hold: ready=%b error=%b, required 1 1", ready, error);
      end
      req = 1'b0;
      tick();
      checks++;
      if (ready !== 1'b0 || error !== 1'b0) begin
        errors++; $display("FAIL unmapped_release: ready=%b error=%b, required 0 0", ready, error);
      end
    end
    s_ready = '0;
  endtask

  task automatic test_back_to_back();
    s_rdata[31:0] = 32'h0000_FFFC; s_rdata[63:32] = 32'hA5A5_0001; s_ready = 4'b0011;
    req = 1'b1; rw = 1'b0; addr = 32'h0000_FFFC;
    tick();
    checks++;
    if (s_en !== 4'b0001 || s_addr !== 32'h0000_FFFC) begin
      errors++; $display("FAIL b2b_first_sel: en=%b addr=%h, required 0001 0000fffc", s_en, s_addr);
    end
    tick();
    checks++;
    if (ready !== 1'b1 || rdata !== 32'h0000_FFFC) begin
      errors++; $display("FAIL b2b_first_done: ready=%b rdata=%h, required 1 0000fffc", ready, rdata);
    end
    // new address presented while request stays high: must not be accepted
    addr = 32'h0001_0000;
    tick();
    checks++;
    if (ready !== 1'b1 || s_en !== 4'b0) begin
      errors++; $display("FAIL b2b_no_accept: ready=%b en=%b, required 1 0000", ready, s_en);
    end
    req = 1'b0;
    tick();
    req = 1'b1;
    tick();
    checks++;
    if (s_en !== 4'b0010 || s_addr !== 32'h0 || ready !== 1'b0) begin
      errors++; $display("FAIL b2b_second_sel: en=%b addr=%h ready=%b, required 0010 00000000 0", s_en, s_addr, ready);
    end
    tick();
    checks++;
    if (ready !== 1'b1 || rdata !== 32'hA5A5_0001) begin
      errors++; $display("FAIL b2b_second_done: ready=%b rdata=%h, required 1 a5a50001", ready, rdata);
    end
    req = 1'b0; s_ready = '0;
    tick();
  endtask

  task automatic test_request_drop();
    s_rdata[31:0] = 32'h0000_7777; s_ready = '0;
    req = 1'b1; rw = 1'b0; addr = 32'h0000_0020;
    tick();
    req = 1'b0;
    tick();
    checks++;
    if (s_en !== 4'b0001 || ready !== 1'b0) begin
      errors++; $display("FAIL drop_access_held: en=%b ready=%b, required 0001 0", s_en, ready);
    end
    s_ready = 4'b0001;
    tick();
    checks++;
    if (ready !== 1'b1 || rdata !== 32'h0000_7777) begin
      errors++; $display("FAIL drop_complete: ready=%b rdata=%h, required 1 00007777", ready, rdata);
    end
    s_ready = '0;
    tick();
    checks++;
    if (ready !== 1'b0) begin
      errors++; $display("FAIL drop_exit: ready=%b, required 0", ready);
    end
  endtask

  task automatic test_reset_midflight();
    s_ready = '0; s_rdata[127:96] = 32'h0BAD_BEEF;
    req = 1'b1; rw = 1'b0; addr = 32'h5000_0004;
    tick();
    checks++;
    if (s_en !== 4'b1000 || s_addr !== 32'h4) begin
      errors++; $display("FAIL midrst_sel: en=%b addr=%h, required 1000 00000004", s_en, s_addr);
    end
    tick();
    rst = 1'b1;
    tick();
    checks++;
    if (s_en !== 4'b0 || ready !== 1'b0 || error !== 1'b0 || s_addr !== 32'h0) begin
      errors++; $display("FAIL midrst_clear: en=%b ready=%b error=%b addr=%h, required 0000 0 0 0", s_en, ready, error, s_addr);
    end
    // request still high while reset held: reset wins, nothing accepted
    tick();
    checks++;
    if (s_en !== 4'b0 || ready !== 1'b0) begin
      errors++; $display("FAIL midrst_reset_wins: en=%b ready=%b, required 0000 0", s_en, ready);
    end
    rst = 1'b0; req = 1'b0;
    tick();
    s_ready = 4'b1000;
    req = 1'b1; addr = 32'h5000_0008;
    tick();
    checks++;
    if (s_en !== 4'b1000 || s_addr !== 32'h8) begin
      errors++; $display("FAIL midrst_after_sel: en=%b addr=%h, required 1000 00000008", s_en, s_addr);
    end
    tick();
    checks++;
    if (ready !== 1'b1 || error !== 1'b0 || rdata !== 32'h0BAD_BEEF) begin
      errors++; $display("FAIL midrst_after_done: ready=%b error=%b rdata=%h, required 1 0 0badbeef", ready, error, rdata);
    end
    req = 1'b0; s_ready = '0;
    tick();
  endtask

  task automatic test_timeout();
    s_ready = 4'b1101;
    req = 1'b1; rw = 1'b0; addr = 32'h0001_0020;
    tick();
    checks++;
    if (s_en !== 4'b0010 || s_addr !== 32'h20) begin
      errors++; $display("FAIL to_sel: en=%b addr=%h, required 0010 00000020", s_en, s_addr);
    end
`ifdef BUS_FABRIC_TIMEOUT_EN
    for (int i = 0; i < 7; i++) tick();
    checks++;
    if (ready !== 1'b0 || s_en !== 4'b0010) begin
      errors++; $display("FAIL to_early: ready=%b en=%b after 7 access cycles, required 0 0010", ready, s_en);
    end
    tick();
    checks++;
    if (ready !== 1'b1 || error !== 1'b1 || rdata !== 32'h0 || s_en !== 4'b0) begin
      errors++; $display("FAIL to_abort: ready=%b error=%b rdata=%h en=%b, required 1 1 00000000 0000", ready, error, rdata, s_en);
    end
    req = 1'b0;
    tick();
`else
    for (int i = 0; i < 1000; i++) tick();
    checks++;
    if (ready !== 1'b0 || error !== 1'b0 || s_en !== 4'b0010) begin
      errors++; $display("FAIL to_waiting: ready=%b error=%b en=%b after 1000 cycles, required 0 0 0010", ready, error, s_en);
    end
    rst = 1'b1; req = 1'b0;
    tick();
    rst = 1'b0;
    tick();
`endif
    s_ready = '0;
  endtask

  initial begin
    test_reset();
    test_read_basic();
    test_write_delayed();
    test_unmapped();
    test_back_to_back();
    test_request_drop();
    test_reset_midflight();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
